// File: rtl/seq_det_pkg.sv
// Shared constants for the serial pattern detector: state codes, default sizes
// and the width helper for length/fill fields.
package seq_det_pkg;

  localparam int MAX_LEN_DEF = 8;
  localparam int CNT_W_DEF   = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_HIT  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Wide enough to hold the value MAX_LEN itself, not just MAX_LEN-1.
  function automatic int len_width(input int max_len);
    return $clog2(max_len) + 1;
  endfunction

endpackage

// File: rtl/seq_match_core.sv
// History shift register, fill counter and masked compare against the pattern.
// match_next is combinational for the bit currently being accepted.
module seq_match_core import seq_det_pkg::*; #(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int LEN_W   = len_width(MAX_LEN)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               accept,
  input  logic               clear,
  input  logic               din,
  input  logic               overlap,
  input  logic [LEN_W-1:0]   len,
  input  logic [MAX_LEN-1:0] pattern,
  output logic               match_next
);

  // The oldest history bit is never needed again, so only MAX_LEN-1 are stored.
  logic [MAX_LEN-2:0] hist;
  logic [MAX_LEN-1:0] hist_next;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   fill;
  logic [LEN_W-1:0]   fill_next;

  always_comb begin
    hist_next = {hist, din};
    fill_next = (fill == LEN_W'(MAX_LEN)) ? fill : fill + LEN_W'(1);
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LEN_W'(i) < len);
    end
    match_next = accept && (fill_next >= len) &&
                 (((hist_next ^ pattern) & mask) == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist <= '0;
      fill <= '0;
    end else if (clear) begin
      hist <= '0;
      fill <= '0;
    end else if (accept) begin
      hist <= hist_next[MAX_LEN-2:0];
      // Non-overlapping mode needs a full fresh window after each match.
      fill <= (match_next && !overlap) ? '0 : fill_next;
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Programmable serial pattern detector: host config handshake, arm/scan FSM,
// registered one-cycle detect pulse and a saturating match counter with stop limit.
module seq_detect_ctrl import seq_det_pkg::*; #(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [MAX_LEN-1:0]       cfg_pattern,
  input  logic [$clog2(MAX_LEN):0] cfg_len,
  input  logic                     cfg_overlap,
  input  logic [CNT_W-1:0]         cfg_limit,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     din_valid,
  input  logic                     din,
  output logic                     din_ready,
  output logic                     seq_detected,
  output logic [CNT_W-1:0]         match_count,
  output logic                     busy,
  output logic                     done
);

  localparam int LEN_W = len_width(MAX_LEN);

  logic [1:0]         state;
  logic [1:0]         state_nxt;
  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   len;
  logic [LEN_W-1:0]   len_clamped;
  logic               overlap;
  logic [CNT_W-1:0]   limit;
  logic               limit_hit;
  logic               cfg_fire;
  logic               start_fire;
  logic               accept;
  logic               match_next;

  assign cfg_ready  = (state == ST_IDLE) || (state == ST_DONE);
  assign busy       = (state == ST_SCAN) || (state == ST_HIT);
  assign done       = (state == ST_DONE);
  assign limit_hit  = (limit != '0) && (match_count == limit);
  assign din_ready  = (state == ST_SCAN) || ((state == ST_HIT) && !limit_hit);
  assign cfg_fire   = cfg_valid && cfg_ready && !abort;
  assign start_fire = start && cfg_ready && !abort;
  assign accept     = din_valid && din_ready && !abort;

  assign len_clamped = (cfg_len == '0)               ? LEN_W'(1) :
                       (cfg_len > LEN_W'(MAX_LEN))   ? LEN_W'(MAX_LEN) : cfg_len;

  seq_match_core #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_core (
    .clk        (clk),
    .reset      (reset),
    .accept     (accept),
    .clear      (start_fire),
    .din        (din),
    .overlap    (overlap),
    .len        (len),
    .pattern    (pattern),
    .match_next (match_next)
  );

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: if (start_fire) state_nxt = ST_SCAN;
        ST_SCAN:          if (match_next) state_nxt = ST_HIT;
        ST_HIT: begin
          // No bit is accepted once the limit is hit, so match_next is low here.
          if (match_next)     state_nxt = ST_HIT;
          else if (limit_hit) state_nxt = ST_DONE;
          else                state_nxt = ST_SCAN;
        end
        default:          state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      pattern      <= '0;
      len          <= LEN_W'(1);
      overlap      <= 1'b0;
      limit        <= '0;
      match_count  <= '0;
      seq_detected <= 1'b0;
    end else begin
      state        <= state_nxt;
      seq_detected <= match_next;
      if (cfg_fire) begin
        pattern <= cfg_pattern;
        len     <= len_clamped;
        overlap <= cfg_overlap;
        limit   <= cfg_limit;
      end
      if (start_fire)
        match_count <= '0;
      else if (match_next && (match_count != '1))
        match_count <= match_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Randomized and directed scoreboard bench for seq_detect_ctrl against a
// queue-based reference model of the detection rules.
module tb_seq_detect_ctrl;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_valid, cfg_ready;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic [7:0] cfg_limit;
  logic       start, abort, din_valid, din, din_ready;
  logic       seq_detected, busy, done;
  logic [7:0] match_count;

  always #5 clk = ~clk;

  seq_detect_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_limit(cfg_limit),
    .start(start), .abort(abort), .din_valid(din_valid), .din(din),
    .din_ready(din_ready), .seq_detected(seq_detected), .match_count(match_count),
    .busy(busy), .done(done)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int due; int cnt; } exp_t;
  exp_t pend[$];

  // Reference model state
  logic [7:0] m_pat;
  int         m_len;
  bit         m_ovl;
  int         m_lim;
  bit         m_armed;
  int         m_cnt;
  bit         m_hist[$];

  function automatic bit m_reached();
    return (m_lim != 0) && (m_cnt == m_lim);
  endfunction
  function automatic bit m_din_ready();
    return m_armed && !m_reached();
  endfunction
  function automatic bit m_cfg_ready();
    return !m_armed || m_reached();
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d want %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pat = '0; m_len = 1; m_ovl = 0; m_lim = 0;
    m_armed = 0; m_cnt = 0;
    m_hist.delete();
    pend.delete();
  endtask

  task automatic model_start();
    m_armed = 1;
    m_cnt = 0;
    m_hist.delete();
  endtask

  task automatic model_accept(input bit b);
    bit hit;
    int n;
    m_hist.push_back(b);
    if (m_hist.size() > MAX_LEN) void'(m_hist.pop_front());
    n = m_hist.size();
    hit = (n >= m_len);
    // Most recent bit pairs with pattern bit 0, earliest with bit len-1.
    for (int i = 0; i < m_len; i++)
      if (hit && (m_hist[n-1-i] != m_pat[i])) hit = 0;
    if (hit) begin
      if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
      pend.push_back('{due: cyc + 1, cnt: m_cnt});
      if (!m_ovl) m_hist.delete();
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      din_valid = 0; cfg_valid = 0; start = 0; abort = 0;
    end
  endtask

  task automatic send_bit(input bit b, input bit v);
    @(negedge clk);
    cfg_valid = 0; start = 0; abort = 0;
    din_valid = v; din = b;
    check("din_ready", din_ready, m_din_ready());
    if (v && m_din_ready()) model_accept(b);
  endtask

  task automatic send_seq(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(bits[i], 1'b1);
  endtask

  task automatic do_cfg(input logic [7:0] p, input int l, input bit o,
                        input int lim, input bit with_start);
    @(negedge clk);
    din_valid = 0; abort = 0;
    cfg_valid = 1; cfg_pattern = p; cfg_len = 4'(l);
    cfg_overlap = o; cfg_limit = 8'(lim); start = with_start;
    check("cfg_ready", cfg_ready, m_cfg_ready());
    if (m_cfg_ready()) begin
      m_pat = p;
      m_len = (l == 0) ? 1 : (l > MAX_LEN) ? MAX_LEN : l;
      m_ovl = o;
      m_lim = lim;
      if (with_start) model_start();
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    din_valid = 0; cfg_valid = 0; abort = 0; start = 1;
    if (m_cfg_ready()) model_start();
  endtask

  task automatic do_abort();
    @(negedge clk);
    din_valid = 0; cfg_valid = 0; start = 0; abort = 1;
    m_armed = 0;
  endtask

  task automatic end_check(input string tag);
    idle(2);
    check({tag, ".busy"},      busy,        m_armed && !m_reached());
    check({tag, ".done"},      done,        m_armed && m_reached());
    check({tag, ".cfg_ready"}, cfg_ready,   m_cfg_ready());
    check({tag, ".din_ready"}, din_ready,   m_din_ready());
    check({tag, ".count"},     match_count, m_cnt);
  endtask

  task automatic quiesce();
    idle(1);
    if (m_armed && !m_reached()) do_abort();
    idle(1);
  endtask

  // Monitor: every cycle, a pulse must appear exactly when one is due.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        check("seq_detected", seq_detected, 1);
        check("pulse_count", match_count, pend[0].cnt);
        void'(pend.pop_front());
      end else begin
        check("seq_quiet", seq_detected, 0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    reset = 1; cfg_valid = 0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 0;
    cfg_limit = '0; start = 0; abort = 0; din_valid = 0; din = 0;
    model_reset();
    #2;
    check("rst.cfg_ready", cfg_ready, 1);
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.count", match_count, 0);
    check("rst.din_ready", din_ready, 0);
    check("rst.seq", seq_detected, 0);
    @(negedge clk);
    reset = 0;

    // Default config after reset: pattern 0, len 1
    do_start();
    send_seq(32'b010, 3);
    end_check("default");

    // Non-overlap 10011, unlimited
    quiesce();
    do_cfg(8'b10011, 5, 0, 0, 1);
    send_seq(32'b1001110011, 10);
    end_check("nonovl10011");
    do_abort();
    end_check("abort_keeps_count");

    // 101 overlap vs non-overlap
    do_cfg(8'b101, 3, 1, 0, 1);
    send_seq(32'b10101, 5);
    end_check("ovl101");
    quiesce();
    do_cfg(8'b101, 3, 0, 0, 1);
    send_seq(32'b10101, 5);
    end_check("nonovl101");

    // Limit 3 with len 1: three back-to-back pulses, then refusal
    quiesce();
    do_cfg(8'b1, 1, 1, 3, 1);
    send_seq(32'b11111, 5);
    end_check("limit3");
    send_bit(1'b1, 1'b1);
    end_check("limit3_done");

    // Length clamping
    do_cfg(8'b1, 0, 0, 0, 1);
    send_seq(32'b1101, 4);
    end_check("len0");
    quiesce();
    do_cfg(8'hB3, MAX_LEN + 3, 0, 0, 1);
    send_seq({15'd0, 1'b0, 8'hB3, 8'hB3}, 17);
    end_check("len_big");
    do_cfg(8'h01, 1, 1, 0, 0);
    send_seq(32'hB3, 8);
    end_check("cfg_busy");

    // Abort discards partial history
    quiesce();
    do_cfg(8'b10011, 5, 0, 0, 1);
    send_seq(32'b1001, 4);
    do_abort();
    end_check("abort_mid");
    do_start();
    send_seq(32'b10011, 5);
    end_check("restart");

    // Async reset during HIT
    quiesce();
    do_cfg(8'h01, 1, 1, 0, 1);
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b1);
    @(posedge clk);
    #2;
    reset = 1;
    #1;
    check("arst.seq", seq_detected, 0);
    check("arst.busy", busy, 0);
    check("arst.count", match_count, 0);
    check("arst.cfg_ready", cfg_ready, 1);
    din_valid = 0;
    model_reset();
    @(negedge clk);
    reset = 0;
    end_check("after_rst");

    // Randomized rounds, some issuing config while still busy
    for (int r = 0; r < 10; r++) begin
      logic [7:0] p;
      int         l, lim, sel;
      bit         o;
      idle(1);
      p   = 8'($urandom);
      sel = $urandom_range(0, 9);
      l   = (sel == 0) ? 0 : (sel == 1) ? $urandom_range(9, 15) : $urandom_range(1, 4);
      o   = 1'($urandom_range(0, 1));
      lim = $urandom_range(0, 4);
      do_cfg(p, l, o, lim, 1'($urandom_range(0, 1)));
      idle(1);
      do_start();
      for (int k = 0; k < 40; k++) begin
        if ((r % 2 == 1) && (k == 20)) begin
          do_abort();
          idle(1);
          do_start();
        end
        send_bit(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
      end
      end_check("rand");
    end

    idle(2);
    check("pend_empty", pend.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
